// File: rtl/tile_index_sequencer.sv
// Tiled matrix-product index walker: emits A/B read and C write tile-row beats for C = A x B.
// Optional zero-dimension start check is compiled in with TILE_SEQ_ZERO_DIM_CHECK_EN.
module tile_index_sequencer #(
  parameter int index_width = 8,
  parameter int k           = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Start,
  input  logic [31:0]            i_Config,
  input  logic                   i_Ready,
  output logic                   o_Valid,
  output logic [2:0]             o_Type,
  output logic [index_width-1:0] o_Row_Index,
  output logic [index_width-1:0] o_Column_Index,
  output logic [k-1:0]           o_Position,
  output logic                   o_Last_Term,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Error,
  output logic [2:0]             o_Dbg_State
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_C = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int unsigned PL = k - 1;
  localparam logic [k-1:0] P_LAST = PL[k-1:0];

  state_t                 state_q, state_d;
  logic [index_width-1:0] mu_q, mu_d, gamma_q, gamma_d, lambda_q, lambda_d;
  logic [index_width-1:0] i_q, i_d, j_q, j_d, t_q, t_d;
  logic [k-1:0]           p_q, p_d;
  logic                   xfer, p_wrap, t_wrap, j_wrap, i_wrap;
  logic                   unused_cfg;

  assign unused_cfg = ^i_Config[31:24];

  // Handshake: a beat transfers when o_Valid & i_Ready on a rising edge; while
  // o_Valid is high and i_Ready low every beat field is held, and o_Valid only
  // falls after the final C beat has transferred.
  assign xfer   = o_Valid & i_Ready;
  assign p_wrap = (p_q == P_LAST);
  assign t_wrap = (t_q == mu_q - 1'b1);
  assign j_wrap = (j_q == gamma_q - 1'b1);
  assign i_wrap = (i_q == lambda_q - 1'b1);

`ifdef TILE_SEQ_ZERO_DIM_CHECK_EN
  logic err_q, err_d, zero_dim;
  assign zero_dim = (i_Config[16 +: index_width] == '0) |
                    (i_Config[8 +: index_width] == '0) |
                    (i_Config[0 +: index_width] == '0);
  assign o_Error  = err_q;
`else
  assign o_Error  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mu_d     = mu_q;
    gamma_d  = gamma_q;
    lambda_d = lambda_q;
    i_d      = i_q;
    j_d      = j_q;
    t_d      = t_q;
    p_d      = p_q;
`ifdef TILE_SEQ_ZERO_DIM_CHECK_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_Start) begin
          mu_d     = i_Config[16 +: index_width];
          gamma_d  = i_Config[8 +: index_width];
          lambda_d = i_Config[0 +: index_width];
          i_d      = '0;
          j_d      = '0;
          t_d      = '0;
          p_d      = '0;
`ifdef TILE_SEQ_ZERO_DIM_CHECK_EN
          if (zero_dim) err_d = 1'b1;
          else          state_d = RD_A;
`else
          state_d = RD_A;
`endif
        end
      end
      RD_A: begin
        if (xfer) begin
          p_d = p_q + 1'b1;
          if (p_wrap) begin
            p_d     = '0;
            state_d = RD_B;
          end
        end
      end
      RD_B: begin
        if (xfer) begin
          p_d = p_q + 1'b1;
          if (p_wrap) begin
            p_d = '0;
            if (t_wrap) begin
              t_d     = '0;
              state_d = WR_C;
            end else begin
              t_d     = t_q + 1'b1;
              state_d = RD_A;
            end
          end
        end
      end
      WR_C: begin
        if (xfer) begin
          p_d = p_q + 1'b1;
          if (p_wrap) begin
            p_d     = '0;
            state_d = RD_A;
            if (j_wrap) begin
              j_d = '0;
              if (i_wrap) begin
                i_d     = '0;
                state_d = FIN;
              end else begin
                i_d = i_q + 1'b1;
              end
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      mu_q     <= '0;
      gamma_q  <= '0;
      lambda_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      t_q      <= '0;
      p_q      <= '0;
`ifdef TILE_SEQ_ZERO_DIM_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mu_q     <= mu_d;
      gamma_q  <= gamma_d;
      lambda_q <= lambda_d;
      i_q      <= i_d;
      j_q      <= j_d;
      t_q      <= t_d;
      p_q      <= p_d;
`ifdef TILE_SEQ_ZERO_DIM_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Beat fields come straight from registered state and counters.
  always_comb begin
    o_Valid        = 1'b0;
    o_Type         = 3'b000;
    o_Row_Index    = '0;
    o_Column_Index = '0;
    o_Position     = '0;
    o_Last_Term    = 1'b0;
    case (state_q)
      RD_A: begin
        o_Valid        = 1'b1;
        o_Type         = 3'b001;
        o_Row_Index    = i_q;
        o_Column_Index = t_q;
        o_Position     = p_q;
      end
      RD_B: begin
        o_Valid        = 1'b1;
        o_Type         = 3'b010;
        o_Row_Index    = t_q;
        o_Column_Index = j_q;
        o_Position     = p_q;
        o_Last_Term    = t_wrap;
      end
      WR_C: begin
        o_Valid        = 1'b1;
        o_Type         = 3'b100;
        o_Row_Index    = i_q;
        o_Column_Index = j_q;
        o_Position     = p_q;
      end
      default: ;
    endcase
  end

  assign o_Busy      = (state_q != IDLE);
  assign o_Dbg_State = state_q;
`ifdef TILE_SEQ_ZERO_DIM_CHECK_EN
  assign o_Done      = (state_q == FIN) | err_q;
`else
  assign o_Done      = (state_q == FIN);
`endif

endmodule

// File: tb/tb_tile_index_sequencer.sv
// Bench for tile_index_sequencer: scoreboard of expected beats built from nested tile loops.
module tb_tile_index_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg = '0;
  logic        ready = 1'b0;
  logic        o_valid, o_last, o_busy, o_done, o_error;
  logic [2:0]  o_type, o_dbg_state;
  logic [7:0]  o_row, o_col;
  logic [1:0]  o_pos;

  int tests_run = 0;
  int tests_failed = 0;
  logic [21:0] exp_q[$];

  tile_index_sequencer #(.index_width(8), .k(2)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Config(cfg), .i_Ready(ready),
    .o_Valid(o_valid), .o_Type(o_type), .o_Row_Index(o_row), .o_Column_Index(o_col),
    .o_Position(o_pos), .o_Last_Term(o_last), .o_Busy(o_busy), .o_Done(o_done),
    .o_Error(o_error), .o_Dbg_State(o_dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] pack(input logic [2:0] ty, input int r, input int c,
                                       input int p, input bit lt);
    logic [7:0] r8, c8;
    logic [1:0] p2;
    r8 = r[7:0];
    c8 = c[7:0];
    p2 = p[1:0];
    return {ty, r8, c8, p2, lt};
  endfunction

  // A zero dimension means 256 tiles when the check is not compiled in.
  task automatic build_model(input int lam, input int mu, input int gam);
    int l_e, m_e, g_e;
    l_e = (lam == 0) ? 256 : lam;
    m_e = (mu == 0) ? 256 : mu;
    g_e = (gam == 0) ? 256 : gam;
    exp_q.delete();
    for (int i = 0; i < l_e; i++)
      for (int j = 0; j < g_e; j++) begin
        for (int t = 0; t < m_e; t++) begin
          for (int p = 0; p < 2; p++) exp_q.push_back(pack(3'b001, i, t, p, 1'b0));
          for (int p = 0; p < 2; p++) exp_q.push_back(pack(3'b010, t, j, p, t == m_e - 1));
        end
        for (int p = 0; p < 2; p++) exp_q.push_back(pack(3'b100, i, j, p, 1'b0));
      end
  endtask

  // ready_mode: 0 always ready, 1 random, 2 three-cycle stall on the second beat.
  task automatic run_seq(input string name, input int lam, input int mu, input int gam,
                         input int ready_mode, input int abort_at, input bit poke);
    int cyc, n, last_x, stall_cnt, total, budget;
    bit seen_done, aborted, prev_stall, poked;
    logic [21:0] cur, prev_beat, exp_b;
    int l_e, m_e, g_e;
    l_e = (lam == 0) ? 256 : lam;
    m_e = (mu == 0) ? 256 : mu;
    g_e = (gam == 0) ? 256 : gam;
    total = l_e * g_e * (2 * 2 * m_e + 2);
    budget = total * 5 + 50;
    build_model(lam, mu, gam);
    cyc = 0; n = 0; last_x = 0; stall_cnt = 0;
    seen_done = 0; aborted = 0; prev_stall = 0; poked = 0; prev_beat = '0;
    @(negedge clk);
    cfg = {8'h00, mu[7:0], gam[7:0], lam[7:0]};
    start = 1'b1;
    ready = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      cur = {o_type, o_row, o_col, o_pos, o_last};
      if (cyc == 1) begin
        tests_run++;
        if ({o_valid, o_busy} !== 2'b11) begin
          tests_failed++;
          $display("FAIL %s start_latency: valid/busy=%b expected 11", name, {o_valid, o_busy});
        end
      end
      if (o_done) begin seen_done = 1; break; end
      if (abort_at >= 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_valid, o_busy, o_done, o_type, o_row, o_col, o_pos, o_last} !== '0) begin
          tests_failed++;
          $display("FAIL %s async_abort: outputs v=%b b=%b ty=%b r=%0d c=%0d expected all 0",
                   name, o_valid, o_busy, o_type, o_row, o_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        exp_q.delete();
        break;
      end
      if (prev_stall) begin
        tests_run++;
        if (!o_valid || cur !== prev_beat) begin
          tests_failed++;
          $display("FAIL %s hold_stable: valid=%b beat=%h expected valid=1 beat=%h",
                   name, o_valid, cur, prev_beat);
        end
      end
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 3) != 0);
        default: begin
          ready = !(n == 1 && stall_cnt < 3);
          if (!ready) stall_cnt++;
        end
      endcase
      if (poke && n == 10 && !poked) begin
        start = 1'b1;
        cfg = $urandom;
        poked = 1;
      end
      if (o_valid && ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s extra_beat: got %h expected none", name, cur);
        end else begin
          exp_b = exp_q.pop_front();
          if (cur !== exp_b) begin
            tests_failed++;
            $display("FAIL %s beat%0d: got ty=%b r=%0d c=%0d p=%0d lt=%b expected %h",
                     name, n, o_type, o_row, o_col, o_pos, o_last, exp_b);
          end
        end
        n++;
        last_x = cyc;
      end
      prev_stall = o_valid && !ready;
      prev_beat = cur;
    end
    ready = 1'b0;
    if (aborted) return;
    tests_run++;
    if (!seen_done || n != total || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s completion: done=%b beats=%0d expected done=1 beats=%0d", name,
               seen_done, n, total);
    end
    tests_run++;
    if (cyc - last_x != 1 || o_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_timing: gap=%0d err=%b expected gap=1 err=0", name,
               cyc - last_x, o_error);
    end
    @(negedge clk);
    tests_run++;
    if ({o_done, o_busy, o_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s done_pulse: done/busy/valid=%b expected 000", name,
               {o_done, o_busy, o_valid});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({o_valid, o_busy, o_done, o_error, o_type, o_row, o_col, o_pos, o_last} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: v=%b b=%b d=%b e=%b ty=%b expected all 0",
               o_valid, o_busy, o_done, o_error, o_type);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_tile();
    run_seq("t1_single", 1, 1, 1, 0, -1, 0);
  endtask

  task automatic test_multi_tile();
    run_seq("t2_multi", 2, 3, 2, 0, -1, 0);
  endtask

  task automatic test_stall();
    run_seq("t3_stall", 1, 1, 1, 2, -1, 0);
  endtask

  task automatic test_reset_abort();
    run_seq("t4_abort", 2, 3, 2, 0, 20, 0);
    run_seq("t4_rerun", 2, 3, 2, 1, -1, 0);
  endtask

  task automatic test_ignore_midrun();
    run_seq("t5_poke", 2, 3, 2, 1, -1, 1);
  endtask

  task automatic test_random();
    int l, m, g;
    for (int r = 0; r < 5; r++) begin
      l = $urandom_range(1, 3);
      m = $urandom_range(1, 3);
      g = $urandom_range(1, 3);
      run_seq($sformatf("rand%0d", r), l, m, g, 1, -1, 0);
    end
  endtask

  task automatic test_zero_dim();
`ifdef TILE_SEQ_ZERO_DIM_CHECK_EN
    @(negedge clk);
    cfg = {8'h00, 8'd0, 8'd1, 8'd1};
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if ({o_error, o_done, o_busy, o_valid} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL t6_zero_err: err/done/busy/valid=%b expected 1100",
               {o_error, o_done, o_busy, o_valid});
    end
    @(negedge clk);
    tests_run++;
    if ({o_error, o_done, o_busy, o_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL t6_zero_after: err/done/busy/valid=%b expected 0000",
               {o_error, o_done, o_busy, o_valid});
    end
    ready = 1'b0;
`else
    run_seq("t6_mu_wrap", 1, 0, 1, 0, -1, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_stall();
    test_reset_abort();
    test_ignore_midrun();
    test_random();
    test_zero_dim();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
